// File: rtl/redirect_controller.sv
// PC redirect controller: arbitrates ID/EX redirect requests, holds a redirect
// while fetch is blocked, drives pipeline flushes and counts applied redirects.
module redirect_controller #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_redirect_req,
  input  logic [WORD_SIZE-1:0] id_redirect_pc,
  input  logic                 ex_redirect_req,
  input  logic [WORD_SIZE-1:0] ex_redirect_pc,
  input  logic                 stall,
  input  logic                 fetch_ready,
  output logic                 pc_load,
  output logic [WORD_SIZE-1:0] pc_load_data,
  output logic                 flush_ifid,
  output logic                 flush_idex,
  output logic                 pending,
  output logic [WORD_SIZE-1:0] redirect_count
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] PEND = 1'b1;

  localparam logic [WORD_SIZE-1:0] CNT_MAX = {WORD_SIZE{1'b1}};
  localparam logic [WORD_SIZE-1:0] CNT_ONE = {{(WORD_SIZE-1){1'b0}}, 1'b1};
  localparam logic [WORD_SIZE-1:0] PC_ZERO = {WORD_SIZE{1'b0}};

  logic [0:0]           state_r;
  logic [0:0]           state_nx_s;
  logic [WORD_SIZE-1:0] target_r;
  logic [WORD_SIZE-1:0] target_nx_s;
  logic [WORD_SIZE-1:0] count_r;
  logic                 load_ok_s;

  assign load_ok_s      = fetch_ready & ~stall;
  assign redirect_count = count_r;

  // Next-state, target selection and combinational outputs; EX is older so it wins.
  always_comb begin
    pc_load      = 1'b0;
    flush_ifid   = 1'b0;
    flush_idex   = 1'b0;
    pending      = 1'b0;
    pc_load_data = target_r;
    state_nx_s   = state_r;
    target_nx_s  = target_r;
    case (state_r)
      IDLE: begin
        if (ex_redirect_req) begin
          flush_ifid   = 1'b1;
          flush_idex   = 1'b1;
          pc_load_data = ex_redirect_pc;
          target_nx_s  = ex_redirect_pc;
          pc_load      = load_ok_s;
          state_nx_s   = load_ok_s ? IDLE : PEND;
        end else if (id_redirect_req) begin
          flush_ifid   = 1'b1;
          pc_load_data = id_redirect_pc;
          target_nx_s  = id_redirect_pc;
          pc_load      = load_ok_s;
          state_nx_s   = load_ok_s ? IDLE : PEND;
        end else begin
          state_nx_s   = IDLE;
        end
      end
      PEND: begin
        pending    = 1'b1;
        flush_ifid = 1'b1;
        // ID requests seen here come from the wrong path and are dropped.
        if (ex_redirect_req) begin
          flush_idex   = 1'b1;
          pc_load_data = ex_redirect_pc;
          target_nx_s  = ex_redirect_pc;
        end else begin
          pc_load_data = target_r;
        end
        pc_load    = load_ok_s;
        state_nx_s = load_ok_s ? IDLE : PEND;
      end
      default: begin
        state_nx_s  = IDLE;
        target_nx_s = PC_ZERO;
      end
    endcase
    if (reset) begin
      pc_load    = 1'b0;
      flush_ifid = 1'b0;
      flush_idex = 1'b0;
      pending    = 1'b0;
    end else begin
      pending    = pending;
    end
  end

  // State and latched redirect target.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= IDLE;
      target_r <= PC_ZERO;
    end else begin
      state_r  <= state_nx_s;
      target_r <= target_nx_s;
    end
  end

  // Saturating count of applied redirects.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= PC_ZERO;
    end else if (pc_load && (count_r != CNT_MAX)) begin
      count_r <= count_r + CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

endmodule

// File: tb/tb_redirect_controller.sv
// Directed self-checking bench for redirect_controller.
module tb_redirect_controller;
  logic        clk = 1'b0;
  logic        reset;
  logic        id_redirect_req;
  logic [15:0] id_redirect_pc;
  logic        ex_redirect_req;
  logic [15:0] ex_redirect_pc;
  logic        stall;
  logic        fetch_ready;
  logic        pc_load;
  logic [15:0] pc_load_data;
  logic        flush_ifid;
  logic        flush_idex;
  logic        pending;
  logic [15:0] redirect_count;

  int compared   = 0;
  int mismatched = 0;

  redirect_controller #(.WORD_SIZE(16)) dut (
    .clk(clk), .reset(reset),
    .id_redirect_req(id_redirect_req), .id_redirect_pc(id_redirect_pc),
    .ex_redirect_req(ex_redirect_req), .ex_redirect_pc(ex_redirect_pc),
    .stall(stall), .fetch_ready(fetch_ready),
    .pc_load(pc_load), .pc_load_data(pc_load_data),
    .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .pending(pending), .redirect_count(redirect_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic idr, input logic [15:0] idp,
                       input logic exr, input logic [15:0] exp_pc,
                       input logic stl, input logic rdy);
    reset = rst; id_redirect_req = idr; id_redirect_pc = idp;
    ex_redirect_req = exr; ex_redirect_pc = exp_pc; stall = stl; fetch_ready = rdy;
    #1;
  endtask

  // Check all combinational outputs of the current cycle.
  task automatic outs(input string tag, input logic ld, input logic [15:0] data,
                      input logic fi, input logic fx, input logic pd);
    chk({tag, ".pc_load"}, {31'd0, pc_load}, {31'd0, ld});
    chk({tag, ".data"}, {16'd0, pc_load_data}, {16'd0, data});
    chk({tag, ".flush_ifid"}, {31'd0, flush_ifid}, {31'd0, fi});
    chk({tag, ".flush_idex"}, {31'd0, flush_idex}, {31'd0, fx});
    chk({tag, ".pending"}, {31'd0, pending}, {31'd0, pd});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2;
    // Reset forces outputs low even with a request present.
    drive(1'b1, 1'b1, 16'h0040, 1'b1, 16'h0100, 1'b0, 1'b1);
    chk("rst.pc_load", {31'd0, pc_load}, 32'd0);
    chk("rst.flush_ifid", {31'd0, flush_ifid}, 32'd0);
    chk("rst.flush_idex", {31'd0, flush_idex}, 32'd0);
    chk("rst.pending", {31'd0, pending}, 32'd0);
    tick();
    chk("rst.count", {16'd0, redirect_count}, 32'd0);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
    outs("idle0", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();

    // ID-only zero-latency redirect.
    drive(1'b0, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b0, 1'b1);
    outs("id_zero", 1'b1, 16'h0040, 1'b1, 1'b0, 1'b0);
    tick();
    chk("id_zero.count", {16'd0, redirect_count}, 32'd1);

    // EX beats ID in the same cycle.
    drive(1'b0, 1'b1, 16'h0040, 1'b1, 16'h0100, 1'b0, 1'b1);
    outs("arb", 1'b1, 16'h0100, 1'b1, 1'b1, 1'b0);
    tick();
    chk("arb.count", {16'd0, redirect_count}, 32'd2);

    // EX request under stall, held through three stalled PEND cycles.
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0200, 1'b1, 1'b1);
    outs("stall_req", 1'b0, 16'h0200, 1'b1, 1'b1, 1'b0);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1);
      outs($sformatf("pend_stall%0d", i), 1'b0, 16'h0200, 1'b1, 1'b0, 1'b1);
      tick();
    end
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
    outs("pend_release", 1'b1, 16'h0200, 1'b1, 1'b0, 1'b1);
    tick();
    chk("pend_release.count", {16'd0, redirect_count}, 32'd3);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
    outs("idle_hold", 1'b0, 16'h0200, 1'b0, 1'b0, 1'b0);
    tick();

    // EX replaces latched target while fetch not ready.
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0200, 1'b0, 1'b0);
    outs("nr_req", 1'b0, 16'h0200, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0300, 1'b0, 1'b0);
    outs("pend_ex", 1'b0, 16'h0300, 1'b1, 1'b1, 1'b1);
    tick();
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
    outs("pend_ex_load", 1'b1, 16'h0300, 1'b1, 1'b0, 1'b1);
    tick();
    chk("pend_ex.count", {16'd0, redirect_count}, 32'd4);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
    tick();
    chk("pend_ex.count_once", {16'd0, redirect_count}, 32'd4);

    // ID request in PEND is ignored.
    drive(1'b0, 1'b0, 16'h0000, 1'b1, 16'h0500, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 16'h0600, 1'b0, 16'h0000, 1'b0, 1'b1);
    outs("pend_id", 1'b1, 16'h0500, 1'b1, 1'b0, 1'b1);
    tick();
    chk("pend_id.count", {16'd0, redirect_count}, 32'd5);

    // Reset in PEND discards the redirect.
    drive(1'b0, 1'b1, 16'h0700, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    chk("pre_rst.pending", {31'd0, pending}, 32'd1);
    drive(1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
    outs("rst_pend", 1'b0, 16'h0700, 1'b0, 1'b0, 1'b0);
    tick();
    chk("rst_pend.count", {16'd0, redirect_count}, 32'd0);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
    outs("post_rst", 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    tick();
    chk("post_rst.count", {16'd0, redirect_count}, 32'd0);

    // Saturation: 65535 back-to-back redirects, then one more.
    drive(1'b0, 1'b1, 16'h0040, 1'b0, 16'h0000, 1'b0, 1'b1);
    repeat (65534) @(posedge clk);
    #1;
    chk("sat.fffe", {16'd0, redirect_count}, 32'h0000FFFE);
    tick();
    chk("sat.ffff", {16'd0, redirect_count}, 32'h0000FFFF);
    chk("sat.pc_load", {31'd0, pc_load}, 32'd1);
    tick();
    chk("sat.hold", {16'd0, redirect_count}, 32'h0000FFFF);
    drive(1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/redirect_controller.md
REDIRECT_CONTROLLER -- requirements
Module: redirect_controller

Interface
REQ-001 Parameter: WORD_SIZE, default 16, width of PC values and the statistics counter.
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 id_redirect_req  input  1  ID-stage PC mismatch (jump target or predicted PC wrong).
REQ-006 id_redirect_pc  input  WORD_SIZE  correct PC for the ID request.
REQ-007 ex_redirect_req  input  1  EX-stage branch resolved as mispredicted.
REQ-008 ex_redirect_pc  input  WORD_SIZE  correct PC for the EX request.
REQ-009 stall  input  1  hazard-unit stall; the PC register must not load while high.
REQ-010 fetch_ready  input  1  instruction memory accepts a new fetch address this cycle.
REQ-011 pc_load  output  1  PC register loads pc_load_data at this edge.
REQ-012 pc_load_data  output  WORD_SIZE  redirect target.
REQ-013 flush_ifid  output  1  invalidate the IF/ID latch at this edge.
REQ-014 flush_idex  output  1  invalidate the ID/EX latch at this edge.
REQ-015 pending  output  1  a redirect is latched and not yet applied.
REQ-016 redirect_count  output  WORD_SIZE  number of redirects applied since reset.

Function
REQ-017 Two states, IDLE and PEND; all outputs except redirect_count are combinational from state, latched target and inputs.
REQ-018 Arbitration: the EX request wins over the ID request in the same cycle, because the EX instruction is older; the losing ID request is discarded and not latched.
REQ-019 IDLE, with an ID-only request: flush_ifid=1, flush_idex=0, target=id_redirect_pc.
REQ-020 IDLE, with an EX request (with or without ID): flush_ifid=1, flush_idex=1, target=ex_redirect_pc.
REQ-021 IDLE, with a request and fetch_ready=1 and stall=0: pc_load=1 and pc_load_data=target in the same cycle (zero latency); the state stays IDLE.
REQ-022 IDLE, with a request and either fetch_ready=0 or stall=1: pc_load=0, the target is latched, and the next state is PEND.
REQ-023 PEND: pending=1; pc_load_data shows the latched target; flush_ifid=1 every PEND cycle, so no wrong-path instruction is decoded.
REQ-024 PEND, with fetch_ready=1 and stall=0: pc_load=1 with the latched target; the next state is IDLE.
REQ-025 PEND, with ex_redirect_req=1: ex_redirect_pc replaces the latched target in this cycle, flush_idex=1, and this cycle's pc_load uses the new target if it is allowed.
REQ-026 PEND, with id_redirect_req=1 and no EX request: the ID request is ignored, because it belongs to the wrong path.
REQ-027 IDLE with no request: pc_load, flush_ifid, flush_idex and pending are all 0; pc_load_data holds the latched target.
REQ-028 redirect_count increments by 1 on every edge where pc_load=1; it saturates at all-ones and does not wrap.
REQ-029 pc_load is never asserted while stall=1 or fetch_ready=0.

Reset
REQ-030 At an edge with reset=1: state becomes IDLE, latched target becomes 0, and redirect_count becomes 0.
REQ-031 While reset=1: pc_load, flush_ifid, flush_idex and pending are forced to 0 regardless of inputs.
REQ-032 Reset asserted in PEND discards the latched redirect; no pc_load follows the release of reset.

Verification
REQ-033 IDLE, id_req=1, id_pc=0x0040, ready=1, stall=0 -> same cycle: pc_load=1, data=0x0040, flush_ifid=1, flush_idex=0; count becomes 1.
REQ-034 IDLE, id_req=1 with id_pc=0x0040 and ex_req=1 with ex_pc=0x0100 in the same cycle -> data=0x0100, flush_idex=1; 0x0040 is never loaded.
REQ-035 IDLE, ex_pc=0x0200, stall=1 for 3 cycles -> pending=1 for 3 cycles with pc_load=0; on the 4th cycle (stall=0): pc_load=1, data=0x0200, pending drops.
REQ-036 PEND holding 0x0200, ex_req=1 with ex_pc=0x0300 while ready=0; next cycle ready=1 -> data=0x0300; count increments exactly once.
REQ-037 Count preloaded at 0xFFFF by repeated redirects, then one more redirect -> count stays 0xFFFF.
REQ-038 In PEND, reset=1 for one cycle, then ready=1 -> pc_load=0 and count=0 after reset.
